// File: rtl/cnt_event_pkg.sv
// Shared event-type encodings and record sizing for the counter event FIFO.
package cnt_event_pkg;

    localparam logic [1:0] EVT_NONE = 2'b00;
    localparam logic [1:0] EVT_WRAP = 2'b01;
    localparam logic [1:0] EVT_THR  = 2'b10;
    localparam logic [1:0] EVT_BOTH = 2'b11;

    // A record is the 2-bit event type stacked on top of the sampled count.
    function automatic int rec_w(input int cnt_w);
        return cnt_w + 2;
    endfunction

endpackage

// File: rtl/cnt_event_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; a pop on a full FIFO frees room for a same-edge push.
module cnt_event_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on each pointer separates the full case from the empty case.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cnt_event_fifo.sv
// Detects wrap / threshold events on an upstream count and queues them as records.
// Define CNT_EVENT_FIFO_FORMAL_EN to compile in assertions and cover points.
module cnt_event_fifo
    import cnt_event_pkg::*;
#(
    parameter int CNT_W  = 11,
    parameter int THRESH = 1000,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     cnt_in,
    input  logic                 cnt_valid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W+1:0]     out_data,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int               RW    = rec_w(CNT_W);
    localparam logic [CNT_W-1:0] THR_V = CNT_W'(THRESH);

    logic [CNT_W-1:0] prev_cnt;
    logic             prev_vld;
    logic             wrap;
    logic             thr;
    logic [1:0]       evt_type;
    logic             push;
    logic             drop_now;
    logic             full;
    logic             empty;
    logic [RW-1:0]    head;

    assign wrap = cnt_valid && prev_vld && (cnt_in < prev_cnt);
    assign thr  = cnt_valid && (cnt_in == THR_V) && (!prev_vld || prev_cnt != THR_V);
    assign push = wrap || thr;

    always_comb begin
        evt_type = EVT_NONE;
        case ({thr, wrap})
            2'b01:   evt_type = EVT_WRAP;
            2'b10:   evt_type = EVT_THR;
            2'b11:   evt_type = EVT_BOTH;
            default: evt_type = EVT_NONE;
        endcase
    end

    // A record is lost only when full and no pop is draining a slot this edge.
    assign drop_now = push && full && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cnt <= '0;
            prev_vld <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (cnt_valid) begin
                prev_cnt <= cnt_in;
                prev_vld <= 1'b1;
            end
            if (drop_now && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    cnt_event_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (out_ready),
        .wdata ({evt_type, cnt_in}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head;

`ifdef CNT_EVENT_FIFO_FORMAL_EN
    logic          past_rst;
    logic          held;
    logic [RW-1:0] last_data;
    logic [DROP_W-1:0] last_drop;
    int            occ;

    always_ff @(posedge clk) begin
        past_rst  <= rst;
        held      <= out_valid && !out_ready;
        last_data <= out_data;
        last_drop <= drop_cnt;
        if (rst) occ <= 0;
        else     occ <= occ + ((push && !drop_now) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        if (!rst && !past_rst) begin
            assert (occ <= DEPTH);
            if (held) assert (out_valid && out_data == last_data);
            assert (drop_cnt >= last_drop);
            if (out_valid) assert (out_data[RW-1:CNT_W] != EVT_NONE);
        end
    end

    cover property (@(posedge clk) disable iff (rst) full);
    cover property (@(posedge clk) disable iff (rst) wrap && thr);
`endif

endmodule

// File: tb/tb_cnt_event_fifo.sv
// Self-checking bench for cnt_event_fifo: vector table, corner sequences, randomized run vs queue model.
module tb_cnt_event_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] cnt_in = '0;
    logic        cnt_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_data;
    logic [7:0]  drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    cnt_event_fifo #(
        .CNT_W(11), .THRESH(1000), .DEPTH(4), .DROP_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .cnt_valid (cnt_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of records plus the last valid sample.
    logic [12:0] mq[$];
    logic [10:0] m_prev = '0;
    bit          m_pvld = 1'b0;
    int          m_drop = 0;

    task automatic model_edge(input bit r, input bit v, input logic [10:0] c, input bit rd);
        bit         w, t;
        logic [1:0] typ;
        if (r) begin
            mq.delete();
            m_prev = '0;
            m_pvld = 1'b0;
            m_drop = 0;
        end else begin
            w = v && m_pvld && (c < m_prev);
            t = v && (c == 11'd1000) && (!m_pvld || m_prev != 11'd1000);
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (w || t) begin
                typ = {t, w};
                if (mq.size() < 4) mq.push_back({typ, c});
                else if (m_drop < 255) m_drop++;
            end
            if (v) begin
                m_prev = c;
                m_pvld = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [10:0] c, input bit rd);
        @(negedge clk);
        rst = r; cnt_valid = v; cnt_in = c; out_ready = rd;
        @(posedge clk);
        model_edge(r, v, c, rd);
        #1;
        check("model out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
        check("model out_data", out_data, (mq.size() > 0) ? mq[0] : 13'd0);
        check("model drop_cnt", drop_cnt, m_drop);
    endtask

    typedef struct {
        bit          rst;
        bit          vld;
        logic [10:0] cnt;
        bit          rdy;
        bit          ev;
        logic [12:0] ed;
        logic [7:0]  edrop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input bit v, input int c, input bit rd,
                                input bit ev, input int ed, input int edrop);
        vec_t x;
        x.rst = r; x.vld = v; x.cnt = 11'(c); x.rdy = rd;
        x.ev = ev; x.ed = 13'(ed); x.edrop = 8'(edrop);
        vecs.push_back(x);
    endfunction

    localparam int R_THR  = 2 * 2048 + 1000;  // {10, 1000}
    localparam int R_W0   = 1 * 2048 + 0;     // {01, 0}
    localparam int R_BOTH = 3 * 2048 + 1000;  // {11, 1000}
    localparam int R_W999 = 1 * 2048 + 999;   // {01, 999}

    initial begin
        int         n;
        logic [12:0] exp_rec[4];

        // Ramp across THRESH: one threshold record, visible for one cycle.
        add(1, 0, 0, 1, 0, 0, 0);
        for (int c = 995; c <= 1005; c++)
            add(0, 1, c, 1, (c == 1000), (c == 1000) ? R_THR : 0, 0);
        // Wrap through zero; first sample after reset is silent.
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 2046, 1, 0, 0, 0);
        add(0, 1, 2047, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, R_W0, 0);
        add(0, 1, 1, 1, 0, 0, 0);
        // Wrap landing on THRESH yields one combined record.
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1200, 0, 0, 0, 0);
        add(0, 1, 1000, 0, 1, R_BOTH, 0);
        add(0, 0, 0, 0, 1, R_BOTH, 0);
        add(0, 0, 0, 1, 0, 0, 0);

        step(1, 0, 0, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset drop_cnt", drop_cnt, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].cnt, vecs[i].rdy);
            check($sformatf("vec[%0d] out_valid", i), out_valid, vecs[i].ev);
            check($sformatf("vec[%0d] out_data", i), out_data, vecs[i].ed);
            check($sformatf("vec[%0d] drop_cnt", i), drop_cnt, vecs[i].edrop);
        end

        // Backpressure: six events into four slots.
        step(1, 0, 0, 0);
        step(0, 1, 999, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, (k % 2 == 0) ? 11'd1000 : 11'd999, 0);
            check("bp head frozen", out_data, R_THR);
        end
        check("bp out_valid", out_valid, 1);
        check("bp drop_cnt", drop_cnt, 2);
        exp_rec[0] = R_THR; exp_rec[1] = R_W999; exp_rec[2] = R_THR; exp_rec[3] = R_W999;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain rec %0d", i), out_data, exp_rec[i]);
            step(0, 0, 0, 1);
        end
        check("drain out_valid low", out_valid, 0);

        // Full FIFO with push and pop on the same edge.
        for (int k = 0; k < 4; k++) step(0, 1, (k % 2 == 0) ? 11'd1000 : 11'd999, 0);
        step(0, 1, 1000, 1);
        check("full push+pop drop_cnt", drop_cnt, 2);
        n = 0;
        while (out_valid && n < 10) begin
            step(0, 0, 0, 1);
            n++;
        end
        check("full push+pop occupancy", n, 4);

        // Mid-operation reset with three queued records and five drops.
        step(1, 0, 0, 0);
        step(0, 1, 999, 0);
        for (int k = 0; k < 9; k++) step(0, 1, (k % 2 == 0) ? 11'd1000 : 11'd999, 0);
        step(0, 0, 0, 1);
        check("pre-rst drop_cnt", drop_cnt, 5);
        step(1, 0, 0, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst drop_cnt", drop_cnt, 0);
        step(0, 1, 5, 1);
        check("post-rst no wrap", out_valid, 0);

        // Drop counter saturation.
        step(1, 0, 0, 0);
        step(0, 1, 999, 0);
        for (int k = 0; k < 300; k++) step(0, 1, (k % 2 == 0) ? 11'd1000 : 11'd999, 0);
        check("drop saturates", drop_cnt, 255);

        // Randomized traffic against the queue model.
        step(1, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            logic [10:0] c;
            case ($urandom_range(0, 5))
                0: c = 11'd1000;
                1: c = 11'd999;
                2: c = 11'd0;
                3: c = 11'd2047;
                4: c = 11'd1001;
                default: c = 11'($urandom);
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, c,
                 $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
